spi_burst_slave: RTL and testbench

Parametrised SPI register-interface slave that oversamples SCLK/MOSI/CS on the system clock. Supports all four SPI modes, configurable address/data widths and multi-word burst transfers with address auto-increment. Sits between the chip-level SPI pins and the register file (PWM/config registers). Successor to the fixed 8-bit, mode-1, single-byte sampled SPI slave.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_edge_sync.sv | 63 ++++++
 rtl/spi_burst_slave.sv | 172 +++++++++++++++++
 tb/tb_spi_burst_slave.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for spi_burst_slave: the FSM state type and the
// helpers that derive header length and bit-counter width from the parameters.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_t;

    function automatic int unsigned hdr_len(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned addr_w, input int unsigned data_w);
        int unsigned longest;
        longest = (addr_w + 1 > data_w) ? addr_w + 1 : data_w;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises the asynchronous SPI pins into clk and turns the synced sclk into
// one-clk sample/shift pulses for the selected CPOL/CPHA mode.
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sclk,
    input  logic i_mosi,
    input  logic i_cs_n,
    output logic o_sample,
    output logic o_shift,
    output logic o_mosi,
    output logic o_cs_n
);

    // Sampling happens on the rising edge in modes 0 and 3, falling in modes 1 and 2.
    localparam bit SAMPLE_RISE = (CPOL == CPHA);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_prev;
    logic                   r_sample;
    logic                   r_shift;
    logic                   r_mosi;
    logic                   r_cs_n;
    logic                   w_rise;
    logic                   w_fall;

    assign w_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
    assign w_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= {SYNC_STAGES{CPOL}};
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_prev <= CPOL;
            r_sample    <= 1'b0;
            r_shift     <= 1'b0;
            r_mosi      <= 1'b0;
            r_cs_n      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_sample    <= SAMPLE_RISE ? w_rise : w_fall;
            r_shift     <= SAMPLE_RISE ? w_fall : w_rise;
            r_mosi      <= r_mosi_sync[SYNC_STAGES-1];
            r_cs_n      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign o_sample = r_sample;
    assign o_shift  = r_shift;
    assign o_mosi   = r_mosi;
    assign o_cs_n   = r_cs_n;

endmodule

// File: rtl/spi_burst_slave.sv
// Oversampled SPI register-interface slave (all CPOL/CPHA modes, R/W header).
// Define SPI_BURST_EN for multi-word bursts with address auto-increment.
module spi_burst_slave #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy
);
    import spi_pkg::*;

    localparam int unsigned HDR_LEN = hdr_len(ADDR_W);
    localparam int unsigned CNT_W   = cnt_width(ADDR_W, DATA_W);
    // Holds only the bits before the current one; the live bit comes from w_mosi.
    localparam int unsigned PW      = ((HDR_LEN > DATA_W) ? HDR_LEN : DATA_W) - 1;
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

    logic w_sample, w_shift, w_mosi, w_cs_n;
    logic [HDR_LEN-1:0] w_hdr;
    logic [DATA_W-1:0]  w_word;
    logic [DATA_W-1:0]  w_tx_src;

    state_t             r_state;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [PW-1:0]      r_shreg;
    logic [DATA_W-1:0]  r_tx;
    logic               r_load;
    logic               r_miso, r_miso_oe, r_wr_en, r_rd_en, r_busy;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wr_data;

    spi_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .CPOL       (CPOL),
        .CPHA       (CPHA)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sclk  (sclk),
        .i_mosi  (mosi),
        .i_cs_n  (cs_n),
        .o_sample(w_sample),
        .o_shift (w_shift),
        .o_mosi  (w_mosi),
        .o_cs_n  (w_cs_n)
    );

    assign w_hdr  = {r_shreg[HDR_LEN-2:0], w_mosi};
    assign w_word = {r_shreg[DATA_W-2:0], w_mosi};
    // A shift edge may land on the very clk rd_data is captured, so bypass it.
    assign w_tx_src = r_load ? rd_data : r_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_tx      <= '0;
            r_load    <= 1'b0;
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            r_busy  <= ~w_cs_n;
            r_load  <= r_rd_en;
            if (w_cs_n) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
                r_shreg   <= '0;
                r_tx      <= '0;
                r_load    <= 1'b0;
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state   <= ST_HDR;
                        r_bit_cnt <= '0;
                    end
                    ST_HDR: if (w_sample) begin
                        r_shreg <= {r_shreg[PW-2:0], w_mosi};
                        if (r_bit_cnt == HDR_LAST) begin
                            r_bit_cnt <= '0;
                            r_addr    <= w_hdr[ADDR_W-1:0];
                            if (w_hdr[HDR_LEN-1]) begin
                                r_state   <= ST_RD;
                                r_rd_en   <= 1'b1;
                                r_miso_oe <= 1'b1;
                            end else begin
                                r_state <= ST_WR;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    ST_WR: begin
`ifdef SPI_BURST_EN
                        if (r_wr_en) r_addr <= r_addr + 1'b1;
`endif
                        if (w_sample) begin
                            r_shreg <= {r_shreg[PW-2:0], w_mosi};
                            if (r_bit_cnt == WORD_LAST) begin
                                r_bit_cnt <= '0;
                                r_wr_data <= w_word;
                                r_wr_en   <= 1'b1;
`ifndef SPI_BURST_EN
                                r_state   <= ST_DONE;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_RD: begin
                        if (r_load) r_tx <= rd_data;
                        if (w_shift) begin
                            r_miso <= w_tx_src[DATA_W-1];
                            r_tx   <= {w_tx_src[DATA_W-2:0], 1'b0};
                        end
                        if (w_sample) begin
                            if (r_bit_cnt == WORD_LAST) begin
                                r_bit_cnt <= '0;
`ifdef SPI_BURST_EN
                                r_addr    <= r_addr + 1'b1;
                                r_rd_en   <= 1'b1;
`else
                                r_state   <= ST_DONE;
                                r_miso    <= 1'b0;
                                r_miso_oe <= 1'b0;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_DONE: r_state <= ST_DONE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign miso    = r_miso;
    assign miso_oe = r_miso_oe;
    assign addr    = r_addr;
    assign wr_data = r_wr_data;
    assign wr_en   = r_wr_en;
    assign rd_en   = r_rd_en;
    assign busy    = r_busy;

endmodule

// File: tb/tb_spi_burst_slave.sv
// Randomised bench for spi_burst_slave: four SPI modes plus a 10/16-bit build,
// checked against a frame-level model of the register traffic (SPI_BURST_EN aware).
module tb_spi_burst_slave;

    localparam int NDUT = 5;
`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct {
        int dut;
        bit wr;
        int a;
        int d;
    } ev_t;

    function automatic int aw_of(input int m);  return (m == 4) ? 10 : 7;  endfunction
    function automatic int dw_of(input int m);  return (m == 4) ? 16 : 8;  endfunction
    function automatic bit pol_of(input int m); return (m == 2 || m == 3); endfunction
    function automatic bit pha_of(input int m); return (m == 1 || m == 3 || m == 4); endfunction

    function automatic logic [15:0] init_val(input int i);
        if (i == 3) return 16'h003C;
        return 16'((i * 40503) ^ (i >> 2) ^ 16'h5A5A);
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        sclk[NDUT], mosi[NDUT], cs_n[NDUT];
    logic        miso[NDUT], miso_oe[NDUT], wr_en[NDUT], rd_en[NDUT], busy[NDUT];
    logic [9:0]  addr[NDUT];
    logic [15:0] wr_data[NDUT], rd_data[NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned AW = aw_of(g);
        localparam int unsigned DW = dw_of(g);
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_wd, w_rd;
        spi_burst_slave #(
            .ADDR_W     (AW),
            .DATA_W     (DW),
            .CPOL       (pol_of(g)),
            .CPHA       (pha_of(g)),
            .SYNC_STAGES(2)
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .sclk   (sclk[g]),
            .mosi   (mosi[g]),
            .cs_n   (cs_n[g]),
            .miso   (miso[g]),
            .miso_oe(miso_oe[g]),
            .addr   (w_addr),
            .wr_data(w_wd),
            .wr_en  (wr_en[g]),
            .rd_en  (rd_en[g]),
            .rd_data(w_rd),
            .busy   (busy[g])
        );
        assign addr[g]    = 10'(w_addr);
        assign wr_data[g] = 16'(w_wd);
        assign w_rd       = DW'(rd_data[g]);
    end

    // Register file seen by the DUTs, plus a log of every strobe.
    logic [15:0] rf_mem[1024];
    ev_t         evq[$];
    int          viol = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) rf_mem[i] <= init_val(i);
        end
        for (int i = 0; i < NDUT; i++) begin
            if (wr_en[i]) begin
                rf_mem[addr[i]] <= wr_data[i];
                evq.push_back('{dut: i, wr: 1'b1, a: int'(addr[i]), d: int'(wr_data[i])});
            end
            if (rd_en[i]) begin
                rd_data[i] <= rf_mem[addr[i]];
                evq.push_back('{dut: i, wr: 1'b0, a: int'(addr[i]), d: 0});
            end
            if ((wr_en[i] && rd_en[i]) || ((wr_en[i] || rd_en[i]) && !busy[i])) viol++;
        end
    end

    int          total = 0;
    int          bad = 0;
    int          H;
    int          ev_rd = 0;
    int          nrx;
    logic [15:0] ref_mem[1024];
    logic [15:0] tx_words[4], rx_words[4], exp_rx[4];
    ev_t         exq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_ev(input ev_t e);
        return {2'b0, 3'(e.dut), e.wr, 10'(e.a), 16'(e.d)};
    endfunction

    function automatic logic [31:0] pack_out(input int i);
        return {1'b0, miso[i], miso_oe[i], wr_en[i], rd_en[i], busy[i], addr[i], wr_data[i]};
    endfunction

    task automatic ref_init();
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    endtask

    task automatic spi_bit(input int m, input logic b, output logic r);
        if (!pha_of(m)) begin
            mosi[m] = b;
            repeat (H) @(negedge clk);
            sclk[m] = ~sclk[m];
            r = miso[m];
            repeat (H) @(negedge clk);
            sclk[m] = ~sclk[m];
        end else begin
            sclk[m] = ~sclk[m];
            mosi[m] = b;
            repeat (H) @(negedge clk);
            sclk[m] = ~sclk[m];
            r = miso[m];
            repeat (H) @(negedge clk);
        end
    endtask

    // Master side: header, then nw words; abort_at >= 0 raises cs_n after that many data bits.
    task automatic frame(input int m, input logic [15:0] hdr, input int nw, input int abort_at);
        logic r;
        int   sent = 0;
        H = $urandom_range(6, 8);
        cs_n[m] = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = aw_of(m); i >= 0; i--) spi_bit(m, hdr[i], r);
        for (int w = 0; w < nw; w++) begin
            rx_words[w] = '0;
            for (int i = dw_of(m) - 1; i >= 0; i--) begin
                if (abort_at >= 0 && sent >= abort_at) break;
                spi_bit(m, tx_words[w][i], r);
                rx_words[w][i] = r;
                sent++;
            end
        end
        repeat (H) @(negedge clk);
        cs_n[m] = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Expected register traffic for one frame, derived from the header/word rules.
    task automatic model(input int m, input logic [15:0] hdr, input int nw, input int abort_at);
        int aw    = aw_of(m);
        int dw    = dw_of(m);
        int amask = (1 << aw) - 1;
        int dmask = (1 << dw) - 1;
        int a     = int'(hdr) & amask;
        int full  = (abort_at < 0) ? nw : abort_at / dw;
        int nwr   = BURST ? full : ((full > 0) ? 1 : 0);
        nrx = 0;
        if (hdr[aw]) begin
            exq.push_back('{dut: m, wr: 1'b0, a: a, d: 0});
            nrx = full;
            for (int w = 0; w < full; w++) begin
                if (BURST) begin
                    exp_rx[w] = 16'(int'(ref_mem[(a + w) & amask]) & dmask);
                    exq.push_back('{dut: m, wr: 1'b0, a: (a + w + 1) & amask, d: 0});
                end else begin
                    exp_rx[w] = (w == 0) ? 16'(int'(ref_mem[a]) & dmask) : 16'h0;
                end
            end
        end else begin
            for (int w = 0; w < nwr; w++) begin
                int ad = (a + w) & amask;
                int d  = int'(tx_words[w]) & dmask;
                exq.push_back('{dut: m, wr: 1'b1, a: ad, d: d});
                ref_mem[ad] = 16'(d);
            end
        end
    endtask

    task automatic run(input string tag, input int m, input logic [15:0] hdr, input int nw, input int abort_at);
        int nev;
        model(m, hdr, nw, abort_at);
        frame(m, hdr, nw, abort_at);
        nev = evq.size() - ev_rd;
        check_eq({tag, ".nev"}, nev, exq.size());
        for (int i = 0; i < exq.size() && i < nev; i++)
            check_eq({tag, ".ev"}, pack_ev(evq[ev_rd + i]), pack_ev(exq[i]));
        for (int w = 0; w < nrx; w++) check_eq({tag, ".miso"}, rx_words[w], exp_rx[w]);
        check_eq({tag, ".idle"}, {busy[m], miso_oe[m], miso[m]}, 0);
        ev_rd = evq.size();
        exq.delete();
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            sclk[i] = pol_of(i);
            mosi[i] = 1'b0;
            cs_n[i] = 1'b1;
        end
        rst_n = 1'b1;
        ref_init();
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) check_eq("reset_out", pack_out(i), 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        tx_words[0] = 16'h00A5;
        run("m1_write", 1, 16'h0005, 1, -1);
        run("m0_read", 0, 16'h0083, 1, -1);
        tx_words[0] = 16'h0011; tx_words[1] = 16'h0022; tx_words[2] = 16'h0033;
        run("burst_wr_wrap", 1, 16'h007E, 3, -1);
        run("m2_burst_rd", 2, 16'h0090, 1, -1);
        run("m3_burst_rd", 3, 16'h0090, 2, -1);
        tx_words[0] = 16'h005A;
        run("abort5", 1, 16'h0012, 1, 5);
        tx_words[0] = 16'h00C3;
        run("after_abort", 1, 16'h0013, 1, -1);
        tx_words[0] = 16'hBEEF;
        run("wide_write", 4, 16'h02A5, 1, -1);

        fork
            frame(1, 16'h0085, 2, -1);
            begin
                repeat (170) @(negedge clk);
                check_eq("oe_in_rd", miso_oe[1], 1);
                rst_n = 1'b0;
                #1;
                check_eq("reset_mid_rd", pack_out(1), 0);
            end
        join
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ref_init();
        repeat (4) @(negedge clk);
        ev_rd = evq.size();
        tx_words[0] = 16'h0077;
        run("post_rst_wr", 1, 16'h0021, 1, -1);
        run("post_rst_rd", 1, 16'h00A1, 1, -1);

        for (int n = 0; n < 40; n++) begin
            int          m  = $urandom_range(0, 4);
            int          aw = aw_of(m);
            int          dw = dw_of(m);
            bit          rd = 1'($urandom_range(0, 1));
            int          nw = $urandom_range(1, 3);
            int          ab = -1;
            logic [15:0] hdr;
            hdr = 16'((int'(rd) << aw) | int'($urandom_range(0, (1 << aw) - 1)));
            for (int w = 0; w < 4; w++) tx_words[w] = 16'($urandom);
            if (!rd && $urandom_range(0, 4) == 0) ab = $urandom_range(0, nw * dw - 1);
            run("random", m, hdr, nw, ab);
        end

        check_eq("strobe_rules", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
